// File: rtl/imem_resp_if.sv
// imem_resp_if: request/response bundle between an instruction fetch unit
// (master) and the imem_resp memory responder (slave).
interface imem_resp_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic        Flush;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;

    modport master (
        output Addr, DataIn, Rd, Wr, Flush,
        input  DataOut, Done, Stall, CacheHit, err
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr, Flush,
        output DataOut, Done, Stall, CacheHit, err
    );
endinterface

// File: rtl/imem_resp.sv
// imem_resp: 1024 x 16-bit instruction memory responder with a fixed
// LATENCY-cycle miss path, read flush on redirect and a bad-request flag.
// Optional single-entry read hit buffer, enabled by defining the macro
// IMEM_RESP_HITBUF_EN; without it CacheHit stays 0 and every read takes
// the full latency.
module imem_resp #(
    parameter int LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    imem_resp_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  idx_q, idx_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        bad_q, bad_d;
    logic        done_q, done_d;
    logic [15:0] dout_q, dout_d;
    logic        err_q, err_d;
    logic        chit_q, chit_d;

    logic [15:0] mem [1024];

    logic        can_accept;
    logic        req_now;
    logic        req_bad;
    logic [9:0]  req_idx;
    logic        commit_wr;
    logic        read_ok;
    logic        flush_rd;
    logic        hit_now;
    logic [15:0] hit_data;
    logic        unused_addr;

    assign unused_addr = ^bus.Addr[15:11];

    // Decode the incoming request and the events of the current cycle
    always_comb begin
        can_accept = (state_q == IDLE) || (state_q == DONE);
        req_now    = can_accept && (bus.Rd || bus.Wr);
        req_idx    = bus.Addr[10:1];
        req_bad    = bus.Addr[0] || (bus.Rd && bus.Wr);
        commit_wr  = (state_q == DONE) && wr_q && !bad_q;
        read_ok    = (state_q == DONE) && rd_q && !bad_q;
        flush_rd   = (state_q == BUSY) && bus.Flush && rd_q && !wr_q;
    end

`ifdef IMEM_RESP_HITBUF_EN
    logic        hb_valid_q, hb_valid_d;
    logic [9:0]  hb_idx_q, hb_idx_d;
    logic [15:0] hb_data_q, hb_data_d;

    // Hit detection and buffer update; a write committing to the same word
    // this cycle blocks the hit so stale data is never returned
    always_comb begin
        hit_now    = req_now && bus.Rd && !bus.Wr && !bus.Addr[0] &&
                     hb_valid_q && (hb_idx_q == req_idx) &&
                     !(commit_wr && (idx_q == req_idx));
        hit_data   = hb_data_q;
        hb_valid_d = hb_valid_q;
        hb_idx_d   = hb_idx_q;
        hb_data_d  = hb_data_q;
        if (read_ok) begin
            hb_valid_d = 1'b1;
            hb_idx_d   = idx_q;
            hb_data_d  = dout_q;
        end else if (commit_wr && (idx_q == hb_idx_q)) begin
            hb_valid_d = 1'b0;
        end
    end

    // Hit buffer registers, invalidated by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_valid_q <= 1'b0;
            hb_idx_q   <= '0;
            hb_data_q  <= '0;
        end else begin
            hb_valid_q <= hb_valid_d;
            hb_idx_q   <= hb_idx_d;
            hb_data_q  <= hb_data_d;
        end
    end
`else
    // No hit buffer: every read goes down the miss path
    always_comb begin
        hit_now  = 1'b0;
        hit_data = 16'h0000;
    end
`endif

    // Next-state and registered-output computation for the request FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        bad_d   = bad_q;
        done_d  = 1'b0;
        dout_d  = 16'h0000;
        err_d   = 1'b0;
        chit_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (req_now) begin
                    idx_d   = req_idx;
                    wdata_d = bus.DataIn;
                    rd_d    = bus.Rd;
                    wr_d    = bus.Wr;
                    bad_d   = req_bad;
                    if (hit_now) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        chit_d  = 1'b1;
                        dout_d  = hit_data;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            BUSY: begin
                if (flush_rd) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = bad_q;
                    dout_d  = (rd_q && !bad_q) ? mem[idx_q] : 16'h0000;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM state, captured request and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= 16'h0000;
            err_q   <= 1'b0;
            chit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            chit_q  <= chit_d;
        end
    end

    // Storage commits writes at the end of their DONE cycle and is never reset
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.Done     = done_q;
    assign bus.DataOut  = dout_q;
    assign bus.err      = err_q;
    assign bus.CacheHit = chit_q;
    assign bus.Stall    = !rst && ((state_q == BUSY) || (req_now && !hit_now));
endmodule

// File: tb/tb_imem_resp.sv
// tb_imem_resp: directed bench for imem_resp with a transaction-level
// reference model compared every cycle plus literal checkpoints.
module tb_imem_resp;
    localparam int LATENCY = 4;

    logic clk;
    logic rst;
    imem_resp_if bus();

    imem_resp #(.LATENCY(LATENCY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 1'b0;
    int cyc      = 0;

    // reference model: one transaction in flight with an absolute completion cycle
    bit          inflight = 1'b0;
    int          done_cycle = 0;
    bit          t_rd, t_wr, t_bad, t_hit;
    logic [9:0]  t_idx;
    logic [15:0] t_data;
    logic [15:0] mem_m [1024];
    bit          known_m [1024];
    bit          hb_valid = 1'b0;
    logic [9:0]  hb_idx = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkBit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic checkWord(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] din, input logic flush);
        bus.Rd     = rd;
        bus.Wr     = wr;
        bus.Addr   = addr;
        bus.DataIn = din;
        bus.Flush  = flush;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic exp_done, input logic exp_stall,
                               input logic [15:0] exp_data, input logic exp_err, input logic exp_hit);
        #1;
        checkBit({name, ".Done"}, bus.Done, exp_done);
        checkBit({name, ".Stall"}, bus.Stall, exp_stall);
        checkWord({name, ".DataOut"}, bus.DataOut, exp_data);
        checkBit({name, ".err"}, bus.err, exp_err);
        checkBit({name, ".CacheHit"}, bus.CacheHit, exp_hit);
    endtask

    // Present a miss request held for the full latency, then drop the inputs
    task automatic holdRequest(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [15:0] din);
        for (int i = 0; i < LATENCY; i++) begin
            applyStimulus(rd, wr, addr, din, 1'b0);
            checkOutput("req_busy", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    // Every cycle: derive required outputs from the in-flight transaction and inputs
    always @(negedge clk) begin : model_blk
        bit          in_done, in_busy, req_now, hit_now;
        logic [9:0]  req_idx;
        logic [15:0] exp_data;
        if (model_on) begin
            if (rst) begin
                inflight = 1'b0;
                hb_valid = 1'b0;
                checkBit("m_rst.Done", bus.Done, 1'b0);
                checkBit("m_rst.Stall", bus.Stall, 1'b0);
                checkBit("m_rst.err", bus.err, 1'b0);
                checkBit("m_rst.CacheHit", bus.CacheHit, 1'b0);
                checkWord("m_rst.DataOut", bus.DataOut, 16'h0000);
            end else begin
                in_done = inflight && (cyc == done_cycle);
                in_busy = inflight && (cyc < done_cycle);
                req_now = !in_busy && (bus.Rd || bus.Wr);
                req_idx = bus.Addr[10:1];
                hit_now = 1'b0;
`ifdef IMEM_RESP_HITBUF_EN
                hit_now = req_now && bus.Rd && !bus.Wr && !bus.Addr[0] && hb_valid &&
                          (hb_idx == req_idx) && !(in_done && t_wr && !t_bad && (t_idx == req_idx));
`endif
                exp_data = 16'h0000;
                if (in_done && t_rd && !t_bad) exp_data = mem_m[t_idx];
                checkBit("m.Done", bus.Done, in_done);
                checkBit("m.Stall", bus.Stall, in_busy || (req_now && !hit_now));
                checkBit("m.err", bus.err, in_done && t_bad);
                checkBit("m.CacheHit", bus.CacheHit, in_done && t_hit);
                if (!(in_done && t_rd && !t_bad) || known_m[t_idx])
                    checkWord("m.DataOut", bus.DataOut, exp_data);

                if (in_done) begin
                    inflight = 1'b0;
                    if (t_wr && !t_bad) begin
                        mem_m[t_idx]   = t_data;
                        known_m[t_idx] = 1'b1;
                        if (hb_valid && (hb_idx == t_idx)) hb_valid = 1'b0;
                    end
                    if (t_rd && !t_bad) begin
                        hb_valid = 1'b1;
                        hb_idx   = t_idx;
                    end
                end
                if (in_busy && bus.Flush && t_rd && !t_wr) inflight = 1'b0;
                if (req_now) begin
                    inflight   = 1'b1;
                    done_cycle = cyc + (hit_now ? 1 : LATENCY);
                    t_rd       = bus.Rd;
                    t_wr       = bus.Wr;
                    t_idx      = req_idx;
                    t_data     = bus.DataIn;
                    t_bad      = bus.Addr[0] || (bus.Rd && bus.Wr);
                    t_hit      = hit_now;
                end
            end
        end
        cyc++;
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        nextCycle();
        model_on = 1'b1;
        checkOutput("reset_state", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        nextCycle();

        // write then read back 0x1234 at 0x0010
        holdRequest(1'b0, 1'b1, 16'h0010, 16'h1234);
        checkOutput("wr10_done", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        holdRequest(1'b1, 1'b0, 16'h0010, 16'h0000);
        checkOutput("rd10_done", 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        nextCycle();
        checkOutput("rd10_after", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // misaligned read reports err
        holdRequest(1'b1, 1'b0, 16'h0011, 16'h0000);
        checkOutput("rd11_err", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        nextCycle();

        // Rd&Wr together is rejected and leaves the word untouched
        holdRequest(1'b0, 1'b1, 16'h0020, 16'h00AA);
        checkOutput("wr20_done", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        holdRequest(1'b0, 1'b1, 16'h0012, 16'hCAFE);
        checkOutput("wr12_done", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        holdRequest(1'b1, 1'b1, 16'h0020, 16'hFFFF);
        checkOutput("rdwr20_err", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        nextCycle();
        holdRequest(1'b1, 1'b0, 16'h0020, 16'h0000);
        checkOutput("rd20_kept", 1'b1, 1'b0, 16'h00AA, 1'b0, 1'b0);
        nextCycle();

        // flush a read in cycle 2, new read in cycle 3 completes in cycle 7
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        checkOutput("fl_c0", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1);
        checkOutput("fl_c2", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        for (int c = 3; c < 7; c++) begin
            applyStimulus(1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0);
            checkOutput("fl_wait", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("fl_c7_done", 1'b1, 1'b0, 16'hCAFE, 1'b0, 1'b0);
        nextCycle();

        // back-to-back: second read presented in the DONE cycle of the first
        for (int c = 0; c < LATENCY; c++) begin
            applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
            checkOutput("b2b_first", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
            nextCycle();
        end
        for (int c = 4; c < 8; c++) begin
            applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
            if (c == 4) checkOutput("b2b_c4", 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
            else        checkOutput("b2b_wait", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("b2b_c8", 1'b1, 1'b0, 16'h00AA, 1'b0, 1'b0);
        nextCycle();

        // reset in cycle 2 of a write aborts it without committing
        holdRequest(1'b0, 1'b1, 16'h0030, 16'h1111);
        checkOutput("wr30_done", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 16'h0030, 16'hBEEF, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b1;
        checkOutput("rst_mid_busy", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        for (int c = 3; c < 8; c++) begin
            checkOutput("post_rst", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
            nextCycle();
        end
        holdRequest(1'b1, 1'b0, 16'h0030, 16'h0000);
        checkOutput("rd30_no_beef", 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
        nextCycle();

        // Flush is ignored during a write and in its DONE cycle
        applyStimulus(1'b0, 1'b1, 16'h0040, 16'h0777, 1'b0);
        checkOutput("wr40_c0", 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 16'h0040, 16'h0777, 1'b1);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b1, 16'h0040, 16'h0777, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        checkOutput("wr40_done_flush", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        holdRequest(1'b1, 1'b0, 16'h0040, 16'h0000);
        checkOutput("rd40_done", 1'b1, 1'b0, 16'h0777, 1'b0, 1'b0);
        nextCycle();

        // repeated read of the same word
        holdRequest(1'b1, 1'b0, 16'h0010, 16'h0000);
        checkOutput("rd10_fill", 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        nextCycle();
`ifdef IMEM_RESP_HITBUF_EN
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        checkOutput("rd10_hit_c0", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("rd10_hit_done", 1'b1, 1'b0, 16'h1234, 1'b0, 1'b1);
        nextCycle();
`else
        holdRequest(1'b1, 1'b0, 16'h0010, 16'h0000);
        checkOutput("rd10_repeat", 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        nextCycle();
`endif
        holdRequest(1'b0, 1'b1, 16'h0010, 16'h5678);
        checkOutput("wr10_5678", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        holdRequest(1'b1, 1'b0, 16'h0010, 16'h0000);
        checkOutput("rd10_5678", 1'b1, 1'b0, 16'h5678, 1'b0, 1'b0);
        nextCycle();
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
